// File: rtl/ode_trace_buffer.sv
// ode_trace_buffer: decimates ODE solver positions, maps them to clamped
// screen rows, tags each kept sample with a wrapping column index and queues
// it in a show-ahead FIFO drained by a valid/ready consumer.
module ode_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int SCALE_SHIFT = 9,
    parameter int Y_CENTER    = 240,
    parameter int Y_MAX       = 479,
    parameter int X_MAX       = 639
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     run,
    input  logic                     step_en,
    input  logic [17:0]              x1,
    input  logic [17:0]              x2,
    input  logic [15:0]              decim,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [9:0]               out_x,
    output logic [9:0]               out_y1,
    output logic [9:0]               out_y2,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    // Position (signed 2.16) to screen row: shift, flip around the centre
    // row, clamp into the visible range. Done at 19 bits so the subtraction
    // cannot wrap.
    function automatic logic [9:0] map_row(input logic [17:0] pos);
        logic signed [18:0] shifted;
        logic signed [18:0] row;
        shifted = $signed({pos[17], pos}) >>> SCALE_SHIFT;
        row     = $signed(19'(Y_CENTER)) - shifted;
        if (row < 0)
            return '0;
        else if (row > $signed(19'(Y_MAX)))
            return 10'(Y_MAX);
        else
            return row[9:0];
    endfunction

    logic [15:0]   dcnt;
    logic [9:0]    xcol;
    logic          stg_v;
    logic [9:0]    stg_x;
    logic [9:0]    stg_y1;
    logic [9:0]    stg_y2;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [9:0]    mem_x  [DEPTH];
    logic [9:0]    mem_y1 [DEPTH];
    logic [9:0]    mem_y2 [DEPTH];

    logic qual;
    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Strobe qualification, FIFO status and push/pop/drop decisions.
    always_comb begin
        qual      = run & step_en;
        capture   = qual & (dcnt == decim);
        out_valid = (wptr != rptr);
        full      = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
        pop       = out_valid & out_ready;
        push      = stg_v & (~full | pop);
        drop      = stg_v & full & ~pop;
    end

    // Decimation counter, column index and stage register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt   <= '0;
            xcol   <= '0;
            stg_v  <= 1'b0;
            stg_x  <= '0;
            stg_y1 <= '0;
            stg_y2 <= '0;
        end else if (clear) begin
            dcnt   <= '0;
            xcol   <= '0;
            stg_v  <= 1'b0;
        end else begin
            if (qual)
                dcnt <= capture ? 16'd0 : dcnt + 16'd1;
            // The stage is always consumed (pushed or dropped) the cycle
            // after capture, so it is valid exactly when a capture happened.
            stg_v <= capture;
            if (capture) begin
                stg_x  <= xcol;
                stg_y1 <= map_row(x1);
                stg_y2 <= map_row(x2);
                xcol   <= (xcol == 10'(X_MAX)) ? 10'd0 : xcol + 10'd1;
            end
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // FIFO storage write.
    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers, and the read path is gated so stale contents never show.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_x[wptr[AW-1:0]]  <= stg_x;
            mem_y1[wptr[AW-1:0]] <= stg_y1;
            mem_y2[wptr[AW-1:0]] <= stg_y2;
        end
    end

    // Show-ahead head read and occupancy.
    always_comb begin
        level  = wptr - rptr;
        out_x  = out_valid ? mem_x[rptr[AW-1:0]]  : 10'd0;
        out_y1 = out_valid ? mem_y1[rptr[AW-1:0]] : 10'd0;
        out_y2 = out_valid ? mem_y2[rptr[AW-1:0]] : 10'd0;
    end

endmodule
